tick_sched: RTL and testbench

Advance-pulse scheduler for the BCD time-of-day core. Owns the real-time prescaler, the pause/run mode, and the manual set buttons. Issues single-cycle `adv` pulses; each pulse advances the core by one second. Sits between the board button pins and the clock core's advance input, in the clock's top level.

---
 rtl/tick_sched_pkg.sv | 17 +
 rtl/tick_sched_btn_cond.sv | 68 ++++++
 rtl/tick_sched.sv | 116 +++++++++++
 tb/tb_tick_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick_sched advance-pulse scheduler.
// Optional debounce is enabled with `define TICK_SCHED_DEBOUNCE_EN.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] BURST_SEC  = 16'd1;
  localparam logic [CNT_W-1:0] BURST_MIN  = 16'd60;
  localparam logic [CNT_W-1:0] BURST_HOUR = 16'd3600;

endpackage

// File: rtl/tick_sched_btn_cond.sv
// Button conditioner: 2-flop synchroniser, optional debouncer, falling-edge strobe.
// Debouncer built only when TICK_SCHED_DEBOUNCE_EN is defined.
module btn_cond #(
  parameter int unsigned DEB_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic level;

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  // Pins idle high, so the chain resets high to avoid a strobe on reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef TICK_SCHED_DEBOUNCE_EN
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic [DW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == DW'(DEB_CYCLES - 1)) deb_d = sync2_q;
      else                              cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign level = deb_q;
`else
  assign level = sync2_q;
`endif

  assign fall = prev_q & ~level;

endmodule

// File: rtl/tick_sched.sv
// Advance-pulse scheduler: real-time prescaler, pause/run mode and manual set bursts.
// Build with TICK_SCHED_DEBOUNCE_EN defined to debounce the button pins.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 20000000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned DEB_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pause,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_hour,
  output logic       adv,
  output logic       paused,
  output logic       busy,
  output logic [1:0] state
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic pause_fall, sec_fall, min_fall, hour_fall;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_pause (
    .clk(clk), .rst_n(rst_n), .pin(btn_pause), .fall(pause_fall)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_sec (
    .clk(clk), .rst_n(rst_n), .pin(btn_sec), .fall(sec_fall)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_min (
    .clk(clk), .rst_n(rst_n), .pin(btn_min), .fall(min_fall)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_hour (
    .clk(clk), .rst_n(rst_n), .pin(btn_hour), .fall(hour_fall)
  );

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pend_q, pend_d;
  logic             adv_q, adv_d;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    pend_d  = pend_q;
    adv_d   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (presc_q == PW'(DIV - 1)) begin
          presc_d = '0;
          // A wrap coinciding with a pause would land its pulse in PAUSE; drop it.
          adv_d   = ~pause_fall;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (pause_fall) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (pause_fall) begin
          state_d = ST_RUN;
        end else if (hour_fall) begin
          rem_d   = BURST_HOUR;
          adv_d   = 1'b1;
          state_d = ST_BURST;
        end else if (min_fall) begin
          rem_d   = BURST_MIN;
          adv_d   = 1'b1;
          state_d = ST_BURST;
        end else if (sec_fall) begin
          rem_d   = BURST_SEC;
          adv_d   = 1'b1;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (pause_fall) pend_d = 1'b1;
        if (adv_q) begin
          rem_d = rem_q - 1'b1;
        end else if (rem_q != '0) begin
          adv_d = 1'b1;
        end else begin
          state_d = (pend_q | pause_fall) ? ST_RUN : ST_PAUSE;
          pend_d  = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      presc_q <= '0;
      rem_q   <= '0;
      pend_q  <= 1'b0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      adv_q   <= adv_d;
    end
  end

  assign adv    = adv_q;
  assign paused = (state_q != ST_RUN);
  assign busy   = (state_q == ST_BURST);
  assign state  = state_q;

endmodule

// File: tb/tb_tick_sched.sv
// Directed testbench for tick_sched with CLK_HZ=10, TICK_HZ=1.
// Latencies adapt when TICK_SCHED_DEBOUNCE_EN is defined (DEB_CYCLES=8).
module tb_tick_sched;

`ifdef TICK_SCHED_DEBOUNCE_EN
  localparam int SL        = 10;
  localparam int PRESS_LEN = 20;
`else
  localparam int SL        = 2;
  localparam int PRESS_LEN = 1;
`endif
  localparam int DIV        = 10;
  localparam int HELD       = (SL + 1) % DIV;
  localparam int RESUME_LAT = SL + 1 + DIV - HELD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_pause = 1'b1;
  logic       btn_sec = 1'b1;
  logic       btn_min = 1'b1;
  logic       btn_hour = 1'b1;
  logic       adv, paused, busy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  tick_sched #(
    .CLK_HZ(10),
    .TICK_HZ(1),
    .DEB_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_pause(btn_pause),
    .btn_sec(btn_sec),
    .btn_min(btn_min),
    .btn_hour(btn_hour),
    .adv(adv),
    .paused(paused),
    .busy(busy),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_pause(input string tag);
    btn_pause = 1'b0;
    for (int i = 0; i < SL; i++) step();
    chk({tag, "_lag"}, paused, 0);
    step();
    chk({tag, "_paused"}, paused, 1);
    btn_pause = 1'b1;
  endtask

  // Adv buttons are already low at the current step; pause_at < 0 means no pause press.
  task automatic run_burst(input string tag, input int n, input int pause_at, input int end_state);
    int adv_cnt, busy_cnt, dbl;
    logic prev_adv;
    adv_cnt = 0; busy_cnt = 0; dbl = 0; prev_adv = 1'b0;
    for (int i = 0; i < SL; i++) step();
    chk({tag, "_pre_busy"}, busy, 0);
    for (int i = 0; i < 2 * n; i++) begin
      step();
      if (i == 0) begin
        chk({tag, "_first_adv"}, adv, 1);
        btn_sec = 1'b1; btn_min = 1'b1; btn_hour = 1'b1;
      end
      if (i == pause_at) btn_pause = 1'b0;
      if (i == pause_at + PRESS_LEN) btn_pause = 1'b1;
      if (adv === 1'b1) adv_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (adv === 1'b1 && prev_adv === 1'b1) dbl++;
      prev_adv = adv;
    end
    btn_pause = 1'b1;
    chk({tag, "_adv_count"}, adv_cnt, n);
    chk({tag, "_busy_cycles"}, busy_cnt, 2 * n);
    chk({tag, "_back_to_back"}, dbl, 0);
    step();
    chk({tag, "_end_state"}, state, end_state);
    chk({tag, "_end_busy"}, busy, 0);
  endtask

  initial begin
    int cnt, first, last, gaps_bad, n;

    // Reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_adv", adv, 0);
    chk("rst_paused", paused, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    step(); step(); step();
    chk("rst_hold_adv", adv, 0);
    rst_n = 1'b1;

    // Free running: pulses at steps 10, 20, ... 100
    cnt = 0; first = 0; last = 0; gaps_bad = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (adv === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
        else if (i - last != DIV) gaps_bad++;
        last = i;
      end
    end
    chk("run_count", cnt, 10);
    chk("run_first", first, 10);
    chk("run_last", last, 100);
    chk("run_spacing", gaps_bad, 0);
    chk("run_paused", paused, 0);

    // Pause right after a wrap, idle 50 cycles
    press_pause("pause1");
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (adv === 1'b1) cnt++;
    end
    chk("pause_no_adv", cnt, 0);
    chk("pause_state", state, 1);

    // Resume: held prescaler value gives a shortened first period
    btn_pause = 1'b0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == PRESS_LEN + SL) btn_pause = 1'b1;
      if (adv === 1'b1) begin
        n = i;
        break;
      end
    end
    btn_pause = 1'b1;
    chk("resume_latency", n, RESUME_LAT);
    chk("resume_paused", paused, 0);

    // Minute burst from PAUSE
    press_pause("pause2");
    btn_min = 1'b0;
    run_burst("min", 60, -1, 1);

    // Hour and sec together: hour wins; pause mid-burst returns to RUN
    btn_hour = 1'b0;
    btn_sec  = 1'b0;
    run_burst("hour", 3600, 100, 0);
    chk("hour_paused_after", paused, 0);

    // Reset during an hour burst after 30 pulses
    press_pause("pause3");
    btn_hour = 1'b0;
    for (int i = 0; i < SL; i++) step();
    cnt = 0;
    for (int i = 0; i <= 58; i++) begin
      step();
      if (i == 0) btn_hour = 1'b1;
      if (adv === 1'b1) cnt++;
    end
    chk("abort_pulses", cnt, 30);
    chk("abort_adv_before", adv, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_adv", adv, 0);
    chk("abort_busy", busy, 0);
    chk("abort_state", state, 0);
    step(); step();
    rst_n = 1'b1;
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (adv === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("abort_restart_latency", n, DIV);
    chk("abort_restart_state", state, 0);

`ifdef TICK_SCHED_DEBOUNCE_EN
    // Glitch filtering on btn_sec in PAUSE
    press_pause("pause4");
    btn_sec = 1'b0;
    for (int i = 0; i < 5; i++) step();
    btn_sec = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (adv === 1'b1) cnt++;
    end
    chk("glitch_adv", cnt, 0);
    chk("glitch_state", state, 1);
    btn_sec = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 19) btn_sec = 1'b1;
      if (adv === 1'b1) cnt++;
    end
    chk("pulse_adv", cnt, 1);
    chk("pulse_state", state, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
